// File: rtl/loom_scan_deser.sv
// Packs an MSB-first serial scan capture into WordWidth-bit words and queues them for host readout.
// Latency: last bit edge to rd_valid_o is 1 cycle; scan_done_i to done_o is 2 cycles.
// Backpressure: host side is valid/ready; the serial side cannot stall, so words arriving on a full FIFO are dropped and overflow_o is set.
module loom_scan_deser #(
    parameter int WordWidth = 32,
    parameter int FifoDepth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 scan_in_i,
    input  logic                 scan_valid_i,
    input  logic                 scan_done_i,
    output logic                 rd_valid_o,
    output logic [WordWidth-1:0] rd_data_o,
    input  logic                 rd_ready_i,
    output logic [31:0]          bit_count_o,
    output logic                 overflow_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int AW = $clog2(FifoDepth);
    localparam int CW = $clog2(WordWidth);
    localparam logic [CW:0] WL = (CW+1)'(WordWidth);

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WordWidth-1:0]   shreg_q;
    logic [CW-1:0]          pcnt_q;
    logic [31:0]            bit_count_q;
    logic                   overflow_q;
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic [WordWidth-1:0]   mem [FifoDepth];

    logic                   take, last_bit, push, pop, full, wr_en;
    logic [WordWidth-1:0]   push_word;
    logic [CW:0]            pad_sh;

    assign take     = !start_i && (state_q == COLLECT) && scan_valid_i;
    assign last_bit = (pcnt_q == CW'(WordWidth - 1));
    assign pad_sh   = WL - {1'b0, pcnt_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_word = '0;
        if (start_i) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: begin
                    // A bit arriving alongside scan_done_i still completes its word.
                    if (scan_valid_i && last_bit) begin
                        push      = 1'b1;
                        push_word = {shreg_q[WordWidth-2:0], scan_in_i};
                    end
                    if (scan_done_i) state_d = FLUSH;
                end
                FLUSH: begin
                    if (pcnt_q != '0) begin
                        push      = 1'b1;
                        push_word = shreg_q << pad_sh;
                    end
                    state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q     <= '0;
            pcnt_q      <= '0;
            bit_count_q <= '0;
        end else if (start_i) begin
            shreg_q     <= '0;
            pcnt_q      <= '0;
            bit_count_q <= '0;
        end else if (take) begin
            shreg_q <= {shreg_q[WordWidth-2:0], scan_in_i};
            pcnt_q  <= last_bit ? '0 : pcnt_q + CW'(1);
            if (bit_count_q != '1) bit_count_q <= bit_count_q + 32'd1;
        end else if (state_q == FLUSH) begin
            pcnt_q <= '0;
        end
    end

    assign rd_valid_o = (wr_ptr_q != rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rd_valid_o && rd_ready_i;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (start_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!start_i && wr_en) mem[wr_ptr_q[AW-1:0]] <= push_word;
    end

    assign rd_data_o   = rd_valid_o ? mem[rd_ptr_q[AW-1:0]] : '0;
    assign bit_count_o = bit_count_q;
    assign overflow_o  = overflow_q;
    assign busy_o      = (state_q == COLLECT) || (state_q == FLUSH);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_loom_scan_deser.sv
// Bench for loom_scan_deser: bit-queue reference model, per-cycle output compare, directed and random captures.
module tb_loom_scan_deser;
    localparam int W = 32;
    localparam int D = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          scan_in_i = 1'b0;
    logic          scan_valid_i = 1'b0;
    logic          scan_done_i = 1'b0;
    logic          rd_ready_i = 1'b0;
    logic          rd_valid_o;
    logic [W-1:0]  rd_data_o;
    logic [31:0]   bit_count_o;
    logic          overflow_o;
    logic          busy_o;
    logic          done_o;

    loom_scan_deser #(.WordWidth(W), .FifoDepth(D)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .scan_in_i(scan_in_i),
        .scan_valid_i(scan_valid_i), .scan_done_i(scan_done_i), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i), .bit_count_o(bit_count_o),
        .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bits of the word in progress, FIFO contents, phase 0..3 = idle/collect/flush/done.
    bit           cur[$];
    logic [W-1:0] m_fifo[$];
    logic [31:0]  m_cnt = 0;
    logic         m_ovf = 0;
    int           m_ph = 0;
    logic [W-1:0] got[$];

    function automatic logic [W-1:0] pack(input bit q[$]);
        logic [W-1:0] w;
        w = '0;
        foreach (q[i]) w = {w[W-2:0], q[i]};
        return w << (W - q.size());
    endfunction

    initial forever begin
        logic [W-1:0] w;
        logic have, pop;
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni || start_i) begin
            cur.delete(); m_fifo.delete();
            m_cnt = 0; m_ovf = 0;
            m_ph = rst_ni ? 1 : 0;
        end else begin
            have = 0; w = '0;
            pop = (m_fifo.size() > 0) && rd_ready_i;
            if (m_ph == 1) begin
                if (scan_valid_i) begin
                    cur.push_back(scan_in_i);
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                    if (cur.size() == W) begin w = pack(cur); have = 1; cur.delete(); end
                end
                if (scan_done_i) m_ph = 2;
            end else if (m_ph == 2) begin
                if (cur.size() > 0) begin w = pack(cur); have = 1; cur.delete(); end
                m_ph = 3;
            end
            if (pop) void'(m_fifo.pop_front());
            if (have) begin
                if (m_fifo.size() < D) m_fifo.push_back(w);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk_i) begin
        chk("rd_valid", 64'(rd_valid_o), 64'(m_fifo.size() > 0));
        chk("rd_data", 64'(rd_data_o), 64'((m_fifo.size() > 0) ? m_fifo[0] : '0));
        chk("bit_count", 64'(bit_count_o), 64'(m_cnt));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("busy", 64'(busy_o), 64'(m_ph == 1 || m_ph == 2));
        chk("done", 64'(done_o), 64'(m_ph == 3));
        if (rd_valid_o && rd_ready_i) got.push_back(rd_data_o);
    end

    int rmode = 1;  // 0: never ready, 1: always ready, 2: random

    function automatic logic rsel();
        if (rmode == 2) return 1'($urandom_range(0, 1));
        return (rmode == 1);
    endfunction

    function automatic logic [W-1:0] gw(input int i);
        if (i < got.size()) return got[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic cyc(input logic st, input logic v, input logic b, input logic d, input logic r);
        @(posedge clk_i); #1;
        start_i = st; scan_valid_i = v; scan_in_i = b; scan_done_i = d; rd_ready_i = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'($urandom_range(0, 1)), 0, rsel());
    endtask

    task automatic send_word(input logic [W-1:0] val, input int n, input logic done_last);
        for (int i = 0; i < n; i++) cyc(0, 1, val[n-1-i], done_last && (i == n-1), rsel());
    endtask

    task automatic t1_capture();
        got.delete();
        rmode = 1;
        cyc(1, 0, 0, 0, 1);
        send_word(32'hDEADBEEF, 32, 0);
        send_word(32'h01234567, 32, 1);
        idle(6);
        chk("t1_words", 64'(got.size()), 64'd2);
        chk("t1_w0", 64'(gw(0)), 64'hDEADBEEF);
        chk("t1_w1", 64'(gw(1)), 64'h01234567);
        chk("t1_bits", 64'(bit_count_o), 64'd64);
        chk("t1_done", 64'(done_o), 64'd1);
    endtask

    logic [W-1:0] wd[10];

    initial begin
        for (int k = 0; k < 10; k++) wd[k] = 32'h1111_1111 * (k + 1) ^ 32'h0F0F_00A5;
        idle(3);
        chk("reset_valid", 64'(rd_valid_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1; rst_ni = 1'b1;
        idle(2);

        t1_capture();

        // partial flush
        got.delete();
        cyc(1, 0, 0, 0, 1);
        send_word(32'hCAFEF00D, 32, 0);
        send_word(32'h000000AB, 8, 1);
        idle(6);
        chk("t2_words", 64'(got.size()), 64'd2);
        chk("t2_w0", 64'(gw(0)), 64'hCAFEF00D);
        chk("t2_w1", 64'(gw(1)), 64'hAB000000);
        chk("t2_bits", 64'(bit_count_o), 64'd40);

        // overflow
        got.delete();
        rmode = 0;
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) send_word(wd[k], 32, k == 8);
        idle(4);
        chk("t3_ovf", 64'(overflow_o), 64'd1);
        chk("t3_valid", 64'(rd_valid_o), 64'd1);
        rmode = 1;
        idle(12);
        chk("t3_words", 64'(got.size()), 64'd8);
        for (int k = 0; k < 8; k++) chk("t3_order", 64'(gw(k)), 64'(wd[k]));

        // full FIFO with push and pop on the same edge
        got.delete();
        rmode = 0;
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) send_word(wd[k], 32, 0);
        send_word(wd[8] >> 1, 31, 0);
        cyc(0, 1, wd[8][0], 0, 1);
        idle(3);
        chk("t4_ovf", 64'(overflow_o), 64'd0);
        chk("t4_popped", 64'(got.size()), 64'd1);
        rmode = 1;
        idle(12);
        chk("t4_words", 64'(got.size()), 64'd9);
        chk("t4_last", 64'(gw(8)), 64'(wd[8]));

        // coincident done and last bit; start with a valid bit
        got.delete();
        cyc(1, 0, 0, 0, 1);
        send_word(32'h5A5AC3C3, 32, 1);
        idle(4);
        chk("t5_words", 64'(got.size()), 64'd1);
        chk("t5_w0", 64'(gw(0)), 64'h5A5AC3C3);
        chk("t5_done", 64'(done_o), 64'd1);
        cyc(1, 1, 1, 0, 1);
        idle(1);
        chk("t5_start_bits", 64'(bit_count_o), 64'd0);
        chk("t5_busy", 64'(busy_o), 64'd1);

        // reset mid-capture
        rmode = 0;
        cyc(1, 0, 0, 0, 0);
        send_word(32'h000DEADB, 20, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b0; scan_valid_i = 1'b0;
        #2;
        chk("t6_bits", 64'(bit_count_o), 64'd0);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_valid", 64'(rd_valid_o), 64'd0);
        chk("t6_data", 64'(rd_data_o), 64'd0);
        idle(2);
        @(posedge clk_i); #1; rst_ni = 1'b1;
        t1_capture();

        // random captures
        for (int it = 0; it < 25; it++) begin
            int nb;
            logic dl;
            rmode = 2;
            nb = $urandom_range(0, 200);
            dl = 1'($urandom_range(0, 1));
            cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, rsel());
            for (int i = 0; i < nb; i++) begin
                while ($urandom_range(0, 3) == 0) idle(1);
                cyc(0, 1, 1'($urandom_range(0, 1)), dl && (i == nb-1), rsel());
            end
            if (!dl && $urandom_range(0, 7) != 0) cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, rsel());
            idle($urandom_range(0, 20));
        end
        rmode = 1;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
